// File: rtl/fp32_op_issuer.sv
// ---------------------------------------------------------------------------
// fp32_op_issuer
//    Drives the rd/wr handshake of the FP32 add/sub unit. Requests from a
//    valid/ready producer are queued in a command FIFO and issued one at a
//    time. Each result is captured on the unit's wr pulse and returned in
//    order, together with its tag, through a result FIFO. A watchdog
//    synthesises an error result and halts the block if the unit stops
//    answering. Only reset leaves the halted state.
//
// Ports
//    clk, reset          clock, synchronous active-high reset
//    cmd_valid/ready     request handshake; cmd_x, cmd_y, cmd_op, cmd_tag
//    res_valid/ready     result handshake; res_z, res_tag, res_err
//    fpu_rd, fpu_op,     operand strobe (one cycle) and operands to the unit
//    fpu_x, fpu_y
//    fpu_z, fpu_wr       result word and one-cycle result pulse from the unit
//    busy                block not idle or commands still queued
//    timeout_err         sticky watchdog flag
// ---------------------------------------------------------------------------
module fp32_op_issuer #(
   parameter int CMD_DEPTH = 4,
   parameter int RES_DEPTH = 4,
   parameter int TAG_W     = 4,
   parameter int TIMEOUT   = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [31:0]      cmd_x,
   input  logic [31:0]      cmd_y,
   input  logic             cmd_op,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_z,
   output logic [TAG_W-1:0] res_tag,
   output logic             res_err,
   output logic             fpu_rd,
   output logic             fpu_op,
   output logic [31:0]      fpu_x,
   output logic [31:0]      fpu_y,
   input  logic [31:0]      fpu_z,
   input  logic             fpu_wr,
   output logic             busy,
   output logic             timeout_err
);

   localparam int CMD_AW = $clog2(CMD_DEPTH);
   localparam int RES_AW = $clog2(RES_DEPTH);
   localparam int CMD_W  = 1 + TAG_W + 64;   // {op, tag, x, y}
   localparam int RES_W  = 32 + TAG_W + 1;   // {z, tag, err}
   localparam int WD_W   = $clog2(TIMEOUT);

   localparam logic [CMD_AW:0]   CMD_FULL     = (CMD_AW+1)'(CMD_DEPTH);
   localparam logic [RES_AW:0]   RES_FULL     = (RES_AW+1)'(RES_DEPTH);
   localparam logic [WD_W-1:0]   WDOG_LAST    = WD_W'(TIMEOUT - 1);
   localparam logic [31:0]       TIMEOUT_WORD = 32'h7FFF_FFFF;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, HALT} state_t;

   state_t state_reg, state_next;

   // ---------------- command FIFO ----------------
   logic [CMD_W-1:0]  cmd_mem [CMD_DEPTH];
   logic [CMD_AW-1:0] cmd_wr_ptr_reg, cmd_rd_ptr_reg;
   logic [CMD_AW:0]   cmd_count_reg;
   logic              cmd_push, cmd_pop, cmd_empty;
   logic [CMD_W-1:0]  cmd_head;

   assign cmd_empty = (cmd_count_reg == '0);
   assign cmd_ready = (cmd_count_reg != CMD_FULL) && (state_reg != HALT);
   assign cmd_push  = cmd_valid && cmd_ready;
   assign cmd_head  = cmd_mem[cmd_rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (cmd_push) begin
         cmd_mem[cmd_wr_ptr_reg] <= {cmd_op, cmd_tag, cmd_x, cmd_y};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_wr_ptr_reg <= '0;
         cmd_rd_ptr_reg <= '0;
         cmd_count_reg  <= '0;
      end else begin
         if (cmd_push) cmd_wr_ptr_reg <= cmd_wr_ptr_reg + CMD_AW'(1);
         if (cmd_pop)  cmd_rd_ptr_reg <= cmd_rd_ptr_reg + CMD_AW'(1);
         cmd_count_reg <= cmd_count_reg + (CMD_AW+1)'(cmd_push) - (CMD_AW+1)'(cmd_pop);
      end
   end

   // ---------------- result FIFO ----------------
   logic [RES_W-1:0]  res_mem [RES_DEPTH];
   logic [RES_AW-1:0] res_wr_ptr_reg, res_rd_ptr_reg;
   logic [RES_AW:0]   res_count_reg;
   logic              res_push, res_pop;
   logic [RES_W-1:0]  res_push_data;
   logic [RES_W-1:0]  res_head;

   assign res_valid = (res_count_reg != '0);
   assign res_pop   = res_valid && res_ready;
   assign res_head  = res_mem[res_rd_ptr_reg];

   // Storage is not reset, so the read port is masked while empty to keep
   // res_z/res_tag/res_err at zero after reset.
   assign res_z   = res_valid ? res_head[RES_W-1 -: 32]   : '0;
   assign res_tag = res_valid ? res_head[TAG_W:1]          : '0;
   assign res_err = res_valid & res_head[0];

   always_ff @(posedge clk) begin
      if (res_push) begin
         res_mem[res_wr_ptr_reg] <= res_push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         res_wr_ptr_reg <= '0;
         res_rd_ptr_reg <= '0;
         res_count_reg  <= '0;
      end else begin
         if (res_push) res_wr_ptr_reg <= res_wr_ptr_reg + RES_AW'(1);
         if (res_pop)  res_rd_ptr_reg <= res_rd_ptr_reg + RES_AW'(1);
         res_count_reg <= res_count_reg + (RES_AW+1)'(res_push) - (RES_AW+1)'(res_pop);
      end
   end

   // ---------------- issue FSM ----------------
   logic [31:0]      fpu_x_reg, fpu_y_reg;
   logic             fpu_op_reg;
   logic [TAG_W-1:0] tag_reg;
   logic [WD_W-1:0]  wdog_reg;
   logic             timeout_err_reg;
   logic             wdog_expire;

   always_comb begin
      state_next    = state_reg;
      cmd_pop       = 1'b0;
      res_push      = 1'b0;
      res_push_data = '0;
      wdog_expire   = 1'b0;
      case (state_reg)
         IDLE: begin
            // Only one operation is ever outstanding, so a free result slot
            // at issue time is guaranteed to still be free when it returns.
            if (!cmd_empty && (res_count_reg != RES_FULL)) begin
               cmd_pop    = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: state_next = WAIT;
         WAIT: begin
            if (fpu_wr) begin
               res_push      = 1'b1;
               res_push_data = {fpu_z, tag_reg, 1'b0};
               state_next    = GAP;
            end else if (wdog_reg == WDOG_LAST) begin
               res_push      = 1'b1;
               res_push_data = {TIMEOUT_WORD, tag_reg, 1'b1};
               wdog_expire   = 1'b1;
               state_next    = HALT;
            end
         end
         // The unit spends the cycle after wr clearing it and ignores rd.
         GAP:     state_next = IDLE;
         HALT:    state_next = HALT;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         fpu_x_reg       <= '0;
         fpu_y_reg       <= '0;
         fpu_op_reg      <= 1'b0;
         tag_reg         <= '0;
         wdog_reg        <= '0;
         timeout_err_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (cmd_pop) begin
            {fpu_op_reg, tag_reg, fpu_x_reg, fpu_y_reg} <= cmd_head;
         end
         // Cleared while in ISSUE so it reads 0 in the first WAIT cycle.
         if (state_reg == ISSUE) begin
            wdog_reg <= '0;
         end else if (state_reg == WAIT) begin
            wdog_reg <= wdog_reg + WD_W'(1);
         end
         if (wdog_expire) timeout_err_reg <= 1'b1;
      end
   end

   assign fpu_rd      = (state_reg == ISSUE);
   assign fpu_x       = fpu_x_reg;
   assign fpu_y       = fpu_y_reg;
   assign fpu_op      = fpu_op_reg;
   assign timeout_err = timeout_err_reg;
   assign busy        = (state_reg != IDLE) || !cmd_empty;

endmodule

// File: doc/fp32_op_issuer.md
Name: fp32_op_issuer

Overview:
- Initiator for the FP32 add/sub unit's rd/wr handshake.
- Buffers operation requests from a valid/ready producer in a command FIFO and issues them one at a time to the unit.
- Captures each result on the unit's wr pulse and returns results in order, with the request tag, through a result FIFO.
- Provides a watchdog that halts the block if the unit stops responding.

Parameters:
- CMD_DEPTH, 4, command FIFO entries (power of 2, ≥2).
- RES_DEPTH, 4, result FIFO entries (power of 2, ≥2).
- TAG_W, 4, request tag width.
- TIMEOUT, 64, max cycles in WAIT before declaring the unit hung (≥8).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  request valid.
- cmd_ready  out  1  request accepted when valid&ready.
- cmd_x  in  32  operand x.
- cmd_y  in  32  operand y.
- cmd_op  in  1  0 = x+y, 1 = x−y.
- cmd_tag  in  TAG_W  opaque tag, returned with the result.
- res_valid  out  1  result FIFO non-empty.
- res_ready  in  1  result popped when valid&ready.
- res_z  out  32  result word.
- res_tag  out  TAG_W  tag of the result.
- res_err  out  1  1 = result synthesised by timeout.
- fpu_rd  out  1  operand strobe to the unit.
- fpu_op  out  1  op to the unit.
- fpu_x  out  32  x to the unit.
- fpu_y  out  32  y to the unit.
- fpu_z  in  32  unit result, valid while fpu_wr=1.
- fpu_wr  in  1  one-cycle result pulse from the unit.
- busy  out  1  high when state≠IDLE or the command FIFO is non-empty.
- timeout_err  out  1  sticky; set on watchdog expiry.

Behaviour:
- Reset (synchronous, active-high): both FIFOs are emptied and the FSM goes to IDLE. Outputs reset to: fpu_rd=0, fpu_op=0, fpu_x=fpu_y=0, timeout_err=0, res_valid=0, res_err=0, busy=0. cmd_ready=1 from the first cycle after reset. Reset overrides everything, including an in-flight operation; a late fpu_wr after reset is ignored.
- cmd_ready = command FIFO not full AND state≠HALT.
- A push on a full FIFO cannot occur. A simultaneous push and pop on the command FIFO is legal.
- Result FIFO: a push and a pop in the same cycle are both honoured. Pointers wrap modulo depth; count width is log2(depth)+1.
- The FSM issues only when the command FIFO is non-empty AND the result FIFO count is < RES_DEPTH. At most one operation is outstanding, so this guarantees space for its result.
- IDLE:
  - If the issue condition holds, pop the command head.
  - Register x/y/op onto fpu_x/fpu_y/fpu_op, hold the tag internally, set fpu_rd=1, and go to ISSUE.
- ISSUE:
  - fpu_rd is high for exactly this one cycle; the next state is WAIT with fpu_rd=0.
  - fpu_x/y/op stay stable from ISSUE until the next ISSUE.
- WAIT:
  - The watchdog counter clears on entry and increments each cycle.
  - If fpu_wr=1: push {fpu_z, tag, err=0} to the result FIFO and go to GAP.
  - Else if the counter reaches TIMEOUT−1: push {32'h7FFFFFFF, tag, err=1}, set timeout_err, and go to HALT.
- GAP:
  - One mandatory idle cycle with fpu_rd=0; the unit spends the cycle after wr clearing wr and ignores rd.
  - Then go to IDLE.
  - Result: minimum issue-to-issue spacing is 3 cycles plus the unit latency.
- HALT:
  - No further issues; cmd_ready=0.
  - The result FIFO keeps draining.
  - Exit is by reset only.
- fpu_wr seen in IDLE, ISSUE, GAP or HALT is ignored and nothing is pushed.
- Ordering: results leave in command order. Tags pass through unmodified.
- Latency: a command accepted at edge N (empty FIFO, idle block) has fpu_rd high in cycle N+1. Its result is visible on res_* the cycle after the fpu_wr cycle.

Test Plan:
- Single add: x=0x3F800000, y=0x40000000, op=0, tag=3 (1.0+2.0). Expect one fpu_rd pulse, then res_z=0x40400000, res_tag=3, res_err=0.
- Back-to-back burst: four commands on consecutive cycles (2.0−1.0, 1.5+1.5, 0+−3.0, 4.0−4.0). Expect res_z 0x3F800000, 0x40400000, 0xC0400000, 0x00000000 in order. fpu_rd must never be high on the cycle after any fpu_wr.
- Backpressure: res_ready=0 while issuing six commands. Expect exactly RES_DEPTH issues, then no fpu_rd and cmd_ready=0 once the command FIFO is also full. Raising res_ready resumes issuing with no loss or duplication.
- Hung unit (stub never asserts fpu_wr): expect a result with z=0x7FFFFFFF and err=1 after exactly TIMEOUT cycles in WAIT, timeout_err=1, and cmd_ready stuck at 0. Reset clears timeout_err and restores operation.
- Reset mid-operation: assert reset during WAIT, with the stub raising fpu_wr one cycle after reset. Expect nothing pushed, empty FIFOs, and all outputs at reset values.
- Spurious wr: pulse fpu_wr while in IDLE. Expect no result pushed and no state change.
